display_scan_mux: RTL and testbench

- Parametrised, self-timed multiplexer for N common-anode 7-segment digits. Next generation of the fixed 4-digit display mux.
- Owns its scan counter; the parent no longer supplies a select signal.
- Adds per-digit blanking, per-digit decimal point, PWM brightness, anti-ghosting dead time and a frame pulse.
- Sits between the digit encoders and the board segment/anode pins.

---
 rtl/display_scan_mux.sv | 72 +++++++
 tb/tb_display_scan_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: self-timed N-digit 7-segment scan multiplexer with blanking,
// decimal points, PWM brightness, anti-ghosting dead time and a frame pulse.
module display_scan_mux #(
    parameter int NUM_DIG  = 4,
    parameter int SEG_W    = 7,
    parameter int PRESC_W  = 16,
    parameter int BRIGHT_W = 4,
    parameter int DEAD     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_DIG*SEG_W-1:0]   segs_in,
    input  logic [NUM_DIG-1:0]         dp_mask,
    input  logic [NUM_DIG-1:0]         blank_mask,
    input  logic [BRIGHT_W-1:0]        brilho,
    output logic [SEG_W-1:0]           seg_out,
    output logic [NUM_DIG-1:0]         an_out,
    output logic                       dp_out,
    output logic [$clog2(NUM_DIG)-1:0] digit_idx,
    output logic                       frame_tick
);
    localparam int IW = $clog2(NUM_DIG);

    logic [PRESC_W-1:0]  presc_cnt;
    logic [SEG_W-1:0]    seg_cap;
    logic                dp_cap;
    logic                blank_cap;
    logic [BRIGHT_W-1:0] bright_cap;
    logic                boundary;
    logic                last;
    logic                on;
    logic [IW-1:0]       nxt;

    always_comb begin
        boundary = en && (&presc_cnt);
        last     = digit_idx == IW'(NUM_DIG - 1);
        nxt      = last ? '0 : digit_idx + 1'b1;
        on       = en && !blank_cap && presc_cnt >= PRESC_W'(DEAD)
                   && presc_cnt[PRESC_W-1 -: BRIGHT_W] <= bright_cap;
    end

    // Capture loads the upcoming digit's inputs, so a slot never sees mid-slot changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt  <= '0;
            digit_idx  <= '0;
            seg_cap    <= '0;
            dp_cap     <= 1'b0;
            blank_cap  <= 1'b0;
            bright_cap <= '0;
            an_out     <= '1;
            seg_out    <= '0;
            dp_out     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            an_out     <= ~(NUM_DIG'(on) << digit_idx);
            seg_out    <= on ? seg_cap : '0;
            dp_out     <= on && dp_cap;
            frame_tick <= boundary && last;
            if (en)
                presc_cnt <= presc_cnt + 1'b1;
            if (boundary) begin
                digit_idx  <= nxt;
                seg_cap    <= segs_in[nxt*SEG_W +: SEG_W];
                dp_cap     <= dp_mask[nxt];
                blank_cap  <= blank_mask[nxt];
                bright_cap <= brilho;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: scoreboard bench; stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_display_scan_mux;
    logic        clk = 0, rst_n = 1, en = 0, clk_run = 0;
    logic [27:0] segs_in = '0;
    logic [3:0]  dp_mask = '0, blank_mask = '0;
    logic [1:0]  brilho = '0;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        dp_out, frame_tick;
    logic [1:0]  digit_idx;

    display_scan_mux #(.NUM_DIG(4), .SEG_W(7), .PRESC_W(4), .BRIGHT_W(2), .DEAD(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .segs_in(segs_in), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .brilho(brilho), .seg_out(seg_out), .an_out(an_out),
        .dp_out(dp_out), .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        logic [1:0] idx;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int vectors = 0, miscompares = 0;
    int p = 0, d = 0;
    logic [6:0] sc = '0;
    logic dc = 0, bc = 0;
    logic [1:0] brc = '0;
    int n_an[4];
    int n_dp, n_ft;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            vectors++;
            if ({an_out, seg_out, dp_out, frame_tick, digit_idx} !== m_e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got an=%b seg=%h dp=%b ft=%b idx=%0d, want an=%b seg=%h dp=%b ft=%b idx=%0d",
                         $time, an_out, seg_out, dp_out, frame_tick, digit_idx,
                         m_e.an, m_e.seg, m_e.dp, m_e.ft, m_e.idx);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Expected response of the current cycle, pushed before the edge that produces it.
    task automatic step();
        exp_t e;
        logic lit;
        int nd;
        lit   = en && !bc && p >= 1 && (p / 4) <= brc;
        e.an  = 4'b1111;
        if (lit) e.an[d] = 1'b0;
        e.seg = lit ? sc : 7'h00;
        e.dp  = lit && dc;
        e.ft  = 1'b0;
        if (en) begin
            if (p == 15) begin
                nd   = (d + 1) % 4;
                e.ft = (nd == 0);
                sc   = segs_in[nd*7 +: 7];
                dc   = dp_mask[nd];
                bc   = blank_mask[nd];
                brc  = brilho;
                d    = nd;
            end
            p = (p + 1) % 16;
        end
        e.idx = 2'(d);
        q.push_back(e);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (an_out == ~(4'b0001 << i)) n_an[i]++;
        n_dp += int'(dp_out);
        n_ft += int'(frame_tick);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int td, input int tp);
        int k = 0;
        while (!(d == td && p == tp) && k < 300) begin
            step();
            k++;
        end
        if (k >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL run_to: got no slot %0d presc %0d, want it within 300 cycles", td, tp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) n_an[i] = 0;
        n_dp = 0;
        n_ft = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_an"}, 32'(an_out), 15);
        check({tag, "_seg"}, 32'(seg_out), 0);
        check({tag, "_dp"}, 32'(dp_out), 0);
        check({tag, "_ft"}, 32'(frame_tick), 0);
        check({tag, "_idx"}, 32'(digit_idx), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1);
    end

    initial begin
        clr();
        segs_in = {7'h08, 7'h04, 7'h02, 7'h01};
        brilho  = 2'd3;
        en      = 1'b1;
        #2 rst_n = 0;
        #3 check_reset("rst");
        #10 rst_n = 1;
        #2 clk_run = 1;

        run(64);
        clr();
        run(64);
        check("full_d0", n_an[0], 15);
        check("full_d1", n_an[1], 15);
        check("full_d3", n_an[3], 15);
        check("frame_ticks", n_ft, 1);

        brilho = 2'd0;
        run(64);
        clr();
        run(64);
        check("dim_d0", n_an[0], 3);
        check("dim_d2", n_an[2], 3);

        blank_mask = 4'b0001;
        dp_mask    = 4'b0100;
        brilho     = 2'd1;
        run(64);
        clr();
        run(64);
        check("blank_d0", n_an[0], 0);
        check("half_d1", n_an[1], 7);
        check("half_d2", n_an[2], 7);
        check("dp_cycles", n_dp, 7);
        check("blank_frame_tick", n_ft, 1);

        blank_mask = 4'b0000;
        dp_mask    = 4'b0000;
        brilho     = 2'd3;
        run_to(1, 5);
        segs_in[13:7] = 7'h7F;
        run_to(1, 4);
        run(16);

        run_to(2, 7);
        en = 1'b0;
        run(10);
        check("hold_idx", 32'(digit_idx), 2);
        en = 1'b1;
        run_to(3, 6);

        @(negedge clk);
        #1 rst_n = 0;
        #1 check_reset("arst");
        p = 0; d = 0; sc = '0; dc = 0; bc = 0; brc = '0;
        @(posedge clk);
        #1 check_reset("arst_hold");
        @(negedge clk);
        #1 rst_n = 1;
        run(70);

        @(negedge clk);
        #1 check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
